// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: seven-segment constants, source/mode encodings and digit lookup.
package bcd_display_pkg;
    typedef enum logic [1:0] {
        MODE_LIVE  = 2'd0,
        MODE_HIGH  = 2'd1,
        MODE_RAW   = 2'd2,
        MODE_BLANK = 2'd3
    } mode_t;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };
    function automatic logic [7:0] seg7_pattern(input logic [3:0] code);
        return code == 4'hF ? SEG_BLANK : code > 4'd9 ? SEG_DASH : SEG_DIGIT[code];
    endfunction
endpackage

// File: rtl/seg7_digit.sv
// seg7_digit: one BCD digit to active-low segments, with DP and blanking.
module seg7_digit
    import bcd_display_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);
    logic [7:0] pat;
    assign pat = blank ? SEG_BLANK : seg7_pattern(code);
    assign seg = {~dp, pat[6:0]};
endmodule

// File: rtl/bcd_display_bank.sv
// bcd_display_bank: shadow-latched multi-source seven-segment bank with
// leading-zero blanking, live decimal points and a blink override.
module bcd_display_bank
    import bcd_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter int LZ_BLANK   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    LOAD,
    input  logic [1:0]              SEL,
    input  logic [4*NUM_DIGITS-1:0] LIVE,
    input  logic [4*NUM_DIGITS-1:0] HIGH,
    input  logic [8*NUM_DIGITS-1:0] RAW,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic                    BLINK_EN,
    output logic [8*NUM_DIGITS-1:0] HEX,
    output logic [1:0]              SHOWING
);
    localparam int CW = $clog2(BLINK_DIV);
    mode_t                   mode;
    logic [8*NUM_DIGITS-1:0] data;
    logic [CW-1:0]           cnt;
    logic                    phase;
    logic [NUM_DIGITS-1:0]   lead;
    logic [8*NUM_DIGITS-1:0] bcd_hex;
    logic [8*NUM_DIGITS-1:0] next_hex;
    logic                    run;
    // BCD sources sit in the low half; the unused upper half stays all ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode <= MODE_BLANK;
            data <= '1;
        end else if (LOAD) begin
            mode <= mode_t'(SEL);
            data <= SEL == MODE_RAW   ? RAW :
                    SEL == MODE_BLANK ? '1 :
                    {{4*NUM_DIGITS{1'b1}}, SEL == MODE_LIVE ? LIVE : HIGH};
        end
    end
    assign SHOWING = mode;
    always_ff @(posedge CLK) begin
        if (RST || !BLINK_EN) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CW'(BLINK_DIV - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
    // Walk down from the most significant digit; digit 0 is never blanked.
    always_comb begin
        lead = '0;
        run  = LZ_BLANK != 0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run     = run && data[4*i +: 4] == 4'd0;
            lead[i] = run;
        end
    end
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7_digit u_digit (
            .code  (data[4*g +: 4]),
            .dp    (DP[g]),
            .blank (lead[g]),
            .seg   (bcd_hex[8*g +: 8])
        );
    end
    assign next_hex = (BLINK_EN && phase) || mode == MODE_BLANK ? '1 :
                      mode == MODE_RAW ? data : bcd_hex;
    always_ff @(posedge CLK) begin
        if (RST) HEX <= '1;
        else     HEX <= next_hex;
    end
endmodule

// File: tb/tb_bcd_display_bank.sv
// tb_bcd_display_bank: directed vectors against a digit-level display model.
module tb_bcd_display_bank;
    localparam int N   = 4;
    localparam int DIV = 4;
    logic        CLK = 0, RST = 0, LOAD = 0, BLINK_EN = 0;
    logic [1:0]  SEL = 0;
    logic [15:0] LIVE = 0, HIGH = 0;
    logic [31:0] RAW = 0;
    logic [3:0]  DP = 0;
    logic [31:0] HEX;
    logic [1:0]  SHOWING;

    bcd_display_bank #(.NUM_DIGITS(N), .BLINK_DIV(DIV), .LZ_BLANK(1)) dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .SEL(SEL), .LIVE(LIVE), .HIGH(HIGH),
        .RAW(RAW), .DP(DP), .BLINK_EN(BLINK_EN), .HEX(HEX), .SHOWING(SHOWING)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0, n_err = 0;
    bit chk_en = 0;
    logic [1:0]  m_sel = 3;
    logic [31:0] m_val = '1;
    int          m_bk = 0;
    logic [31:0] exp_hex = '1;
    logic [1:0]  exp_show = 3;
    localparam logic [7:0] DIGIT_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90,
        8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hFF
    };

    function automatic logic [31:0] render(logic [1:0] sel, logic [31:0] val, logic [3:0] dp, bit dark);
        int msd = 0;
        logic [31:0] r;
        logic [7:0] s;
        if (dark || sel == 2'd3) return '1;
        if (sel == 2'd2) return val;
        for (int d = 0; d < N; d++)
            if (((val >> (4 * d)) & 32'hF) != 0) msd = d;
        for (int d = 0; d < N; d++) begin
            s = d > msd ? 8'hFF : DIGIT_SEG[int'((val >> (4 * d)) & 32'hF)];
            s[7] = ~dp[d];
            r[8*d +: 8] = s;
        end
        return r;
    endfunction

    task automatic cyc();
        logic [31:0] nh, nv;
        logic [1:0]  ns;
        int nb;
        if (RST) begin
            nh = '1; ns = 2'd3; nv = '1; nb = 0;
        end else begin
            nh = render(m_sel, m_val, DP, BLINK_EN && ((m_bk / DIV) % 2 == 1));
            ns = m_sel;
            nv = m_val;
            if (LOAD) begin
                ns = SEL;
                nv = SEL == 2'd0 ? {16'h0, LIVE} : SEL == 2'd1 ? {16'h0, HIGH} :
                     SEL == 2'd2 ? RAW : '1;
            end
            nb = BLINK_EN ? m_bk + 1 : 0;
        end
        @(posedge CLK);
        m_sel = ns; m_val = nv; m_bk = nb; exp_hex = nh; exp_show = ns;
        #1;
    endtask

    task automatic lit(string name, logic [31:0] h, logic [1:0] s);
        n_vec++;
        if (HEX !== h || SHOWING !== s) begin
            n_err++;
            $display("FAIL %s: HEX=%h SHOWING=%0d, want HEX=%h SHOWING=%0d", name, HEX, SHOWING, h, s);
        end
    endtask

    task automatic load(logic [1:0] s, logic [15:0] live, logic [15:0] high, logic [31:0] raw);
        SEL = s; LIVE = live; HIGH = high; RAW = raw; LOAD = 1;
        cyc();
        LOAD = 0;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            n_vec++;
            if (HEX !== exp_hex || SHOWING !== exp_show) begin
                n_err++;
                $display("FAIL model t=%0t: HEX=%h SHOWING=%0d, want HEX=%h SHOWING=%0d",
                         $time, HEX, SHOWING, exp_hex, exp_show);
            end
        end
    end

    initial begin
        RST = 1;
        cyc();
        RST = 0;
        chk_en = 1;
        lit("reset", 32'hFFFFFFFF, 2'd3);
        repeat (3) cyc();
        lit("idle", 32'hFFFFFFFF, 2'd3);

        load(2'd0, 16'h0042, 16'h0, 32'h0);
        lit("live_t1", 32'hFFFFFFFF, 2'd0);
        cyc();
        lit("live_42", 32'hFFFF99A4, 2'd0);
        DP = 4'b0001;
        cyc();
        lit("dp_live", 32'hFFFF9924, 2'd0);
        DP = 4'b0000;

        DP = 4'b0100;
        load(2'd1, 16'h0, 16'h1000, 32'h0);
        cyc();
        lit("high_1000", 32'hF940C0C0, 2'd1);
        DP = 4'b0000;
        load(2'd1, 16'h0, 16'h0AF5, 32'h0);
        cyc();
        lit("dash_blank", 32'hFFBFFF92, 2'd1);
        load(2'd0, 16'h0000, 16'h0, 32'h0);
        cyc();
        lit("all_zero", 32'hFFFFFFC0, 2'd0);

        DP = 4'hF;
        load(2'd2, 16'h0, 16'h0, 32'h12345678);
        cyc();
        lit("raw", 32'h12345678, 2'd2);
        load(2'd3, 16'h0, 16'h0, 32'h0);
        cyc();
        lit("mode3", 32'hFFFFFFFF, 2'd3);
        DP = 4'h0;

        load(2'd0, 16'h0042, 16'h0, 32'h0);
        cyc();
        BLINK_EN = 1;
        for (int k = 1; k <= 13; k++) begin
            cyc();
            lit($sformatf("blink_%0d", k), ((k - 1) / 4) % 2 == 1 ? 32'hFFFFFFFF : 32'hFFFF99A4, 2'd0);
        end
        BLINK_EN = 0;
        cyc();
        lit("blink_off", 32'hFFFF99A4, 2'd0);
        BLINK_EN = 1;
        cyc();
        lit("blink_rerise", 32'hFFFF99A4, 2'd0);
        BLINK_EN = 0;

        SEL = 2'd0; LIVE = 16'h1111; LOAD = 1;
        cyc();
        LIVE = 16'h0009;
        cyc();
        LOAD = 0;
        lit("consec_1", 32'hF9F9F9F9, 2'd0);
        cyc();
        lit("consec_2", 32'hFFFFFF90, 2'd0);

        SEL = 2'd0; LIVE = 16'h0055; LOAD = 1; RST = 1;
        cyc();
        RST = 0;
        lit("rst_load", 32'hFFFFFFFF, 2'd3);
        LIVE = 16'h0007;
        cyc();
        LOAD = 0;
        lit("post_rst_t1", 32'hFFFFFFFF, 2'd0);
        cyc();
        lit("post_rst_t2", 32'hFFFFFFF8, 2'd0);
        repeat (2) cyc();

        @(negedge CLK);
        #1;
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bcd_display_bank.md
BCD_DISPLAY_BANK -- requirements
Module: bcd_display_bank

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of seven-segment digits driven (range 1-8).
REQ-002 The block SHALL have parameter BLINK_DIV, default 25000000, giving clock cycles per blink half-period (minimum 2).
REQ-003 The block SHALL have parameter LZ_BLANK, default 1, enabling leading-zero blanking when 1.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- CLK  input  1  system clock, all state on rising edge
- RST  input  1  synchronous active-high reset
- LOAD  input  1  one-cycle strobe; captures selected source into shadow register
- SEL  input  2  source select sampled on LOAD: 0 = LIVE, 1 = HIGH, 2 = RAW, 3 = blank
- LIVE  input  4*NUM_DIGITS  live BCD value, digit 0 in bits [3:0]
- HIGH  input  4*NUM_DIGITS  stored high-score BCD value, same packing
- RAW  input  8*NUM_DIGITS  raw active-low segment patterns, bypass decode
- DP  input  NUM_DIGITS  decimal-point enables, 1 = lit, applied in BCD modes only
- BLINK_EN  input  1  1 = blank all digits on alternate half-periods
- HEX  output  8*NUM_DIGITS  active-low segments per digit, bit 7 = DP, registered
- SHOWING  output  2  SEL value currently held in shadow register

Function
REQ-005 On LOAD = 1 the block SHALL capture SEL and the matching source (LIVE, HIGH or RAW) into a shadow register; without LOAD the shadow SHALL hold.
REQ-006 HEX SHALL reflect a new shadow value exactly 2 cycles after the LOAD cycle (shadow register, then registered decode).
REQ-007 Digit decode SHALL map 0-9 to 0xC0, 0xF9, 0xA4, 0xB0, 0x99, 0x92, 0x82, 0xF8, 0x80, 0x90; codes 10-14 SHALL give dash 0xBF; code 15 SHALL give blank 0xFF.
REQ-008 In BCD modes, bit 7 of each digit SHALL be cleared (DP lit) when the corresponding DP bit is 1; DP SHALL be sampled live each cycle, not latched on LOAD.
REQ-009 With LZ_BLANK = 1 in BCD modes, zero digits from the most-significant digit downward up to the first nonzero digit SHALL show 0xFF, excluding their DP bit; digit 0 SHALL never be blanked.
REQ-010 In RAW mode HEX SHALL equal the captured RAW bits unmodified by DP or blanking; in mode 3 all digits SHALL be 0xFF.
REQ-011 A blink counter SHALL count 0..BLINK_DIV-1 and wrap, toggling a phase bit on wrap, while BLINK_EN = 1.
REQ-012 When BLINK_EN = 0 the counter and phase SHALL be held at 0; when BLINK_EN = 1 and phase = 1 every HEX digit SHALL be 0xFF (overriding all modes).
REQ-013 Rising BLINK_EN SHALL start with phase 0 (digits visible) for BLINK_DIV cycles.
REQ-014 LOAD asserted on consecutive cycles SHALL capture each cycle; the last capture wins.
REQ-015 SHOWING SHALL update in the same cycle as the shadow register.

Reset
REQ-016 RST = 1 at a clock edge SHALL set shadow data to all 4'hF / 8'hFF, shadow mode to 3, blink counter and phase to 0, HEX to all 0xFF and SHOWING to 3, one cycle later.
REQ-017 RST SHALL take priority over a simultaneous LOAD; a LOAD pending in the pipeline SHALL be discarded.

Structure
REQ-018 Segment constants (digit patterns, dash, blank) and mode encodings SHALL live in shared package bcd_display_pkg.
REQ-019 A combinational sub-module seg7_digit (4-bit code, DP, blank in -> 8-bit pattern) SHALL be instantiated NUM_DIGITS times.

Verification (NUM_DIGITS = 4, BLINK_DIV = 4)
REQ-020 Reset, then no LOAD -> HEX = 0xFFFFFFFF and SHOWING = 3 indefinitely.
REQ-021 SEL = 0, LIVE = 0x0042, LOAD pulse at cycle t -> at t+2 HEX = 0xFF_FF_99_A4 (leading zeros blanked).
REQ-022 SEL = 1, HIGH = 0x1000, DP = 4'b0100, LOAD -> HEX = 0xF9_40_C0_C0; codes 0xA/0xF in a digit give 0xBF/0xFF.
REQ-023 SEL = 2, RAW = 0x12345678, DP = 4'hF, LOAD -> HEX = 0x12345678 exactly.
REQ-024 BLINK_EN raised with HEX showing "42" -> 4 cycles visible, 4 cycles 0xFFFFFFFF, repeating; BLINK_EN low -> visible next cycle.
REQ-025 LOAD and RST in same cycle, then LOAD with LIVE = 0x0007 one cycle later -> HEX stays 0xFFFFFFFF through reset, then 0xFF_FF_FF_F8 two cycles after second LOAD.
